// File: rtl/add_fold_acc.sv
// Fold accumulator behind the adder tree: sums FOLD beats into one result and queues
// completed results in a 2-entry FIFO. in_rdy drives the adder tree enable.
module add_fold_acc #(
  parameter int unsigned SUM_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned FOLD      = 4,
  parameter bit          SIGNED    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [SUM_WIDTH-1:0] in_sum,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [ACC_WIDTH-1:0] out_acc
);

  localparam int unsigned     CntW    = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FOLD - 1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] mem_q [2];
  logic [ACC_WIDTH-1:0] mem_d [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           occ_q, occ_d;
  logic                 in_rdy_q, in_rdy_d;

  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 accept;
  logic                 push;
  logic                 pop;

  always_comb begin
    if (SIGNED) begin
      ext = ACC_WIDTH'($signed(in_sum));
    end else begin
      ext = ACC_WIDTH'(in_sum);
    end
    // The first beat of a fold replaces the accumulator instead of adding to it.
    sum    = (cnt_q == '0) ? ext : acc_q + ext;
    accept = in_vld & in_rdy_q;
    push   = accept & (cnt_q == CntLast);
    pop    = (occ_q != 2'd0) & out_rdy;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;

    if (accept) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      acc_d = sum;
    end
    if (push) begin
      mem_d[wr_ptr_q] = sum;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    // Registered ready keeps one free slot for the completing beat already in flight.
    in_rdy_d = (occ_d < 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      in_rdy_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = (occ_q != 2'd0);
  assign out_acc = mem_q[rd_ptr_q];

  assert property (@(posedge clk) disable iff (rst) !(push && (occ_q == 2'd2)));

endmodule

// File: doc/add_fold_acc.md
# add_fold_acc

Fold accumulator directly downstream of the pipelined multi-input adder tree (`add_multi`). It takes one adder-tree sum per beat and accumulates FOLD consecutive beats into one dot-product result. Completed results go into a 2-entry output queue with valid/ready handshake. The block's ready output drives the adder tree's `en`, stalling it under backpressure.

## Interface
- SUM_WIDTH, 8 — width of incoming adder-tree sum.
- ACC_WIDTH, 16 — accumulator/result width; must be ≥ SUM_WIDTH.
- FOLD, 4 — beats accumulated per result; ≥ 1.
- SIGNED, 1 — 1: in_sum sign-extended; 0: zero-extended.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_vld  in  1  in_sum carries a valid beat.
- in_rdy  out  1  block accepts a beat this cycle; wired to upstream `en`.
- in_sum  in  SUM_WIDTH  adder-tree sum.
- out_vld  out  1  out_acc holds a completed result.
- out_rdy  in  1  consumer accepts out_acc.
- out_acc  out  ACC_WIDTH  completed accumulation, modulo 2^ACC_WIDTH.

## Operation
- Beat accepted iff in_vld && in_rdy.
- ext(x) = in_sum extended to ACC_WIDTH per SIGNED.
- Beat counter cnt, 0..FOLD-1, advances only on accepted beats, wraps FOLD-1 → 0.
- Accepted beat with cnt==0: acc ← ext(in_sum). Otherwise: acc ← acc + ext(in_sum). Plain modular addition; overflow wraps silently, no saturation.
- Accepted beat with cnt==FOLD-1 completes a fold. The result (cnt==0 ? ext : acc+ext) is pushed into the output queue.
- FOLD=1: every accepted beat is pushed as ext(in_sum).
- Output queue: 2-entry FIFO, occupancy occ ∈ {0,1,2}. out_vld = (occ≠0). out_acc = head entry. Pop on out_vld && out_rdy.
- in_rdy is a register:
  - next value = 1 iff next occupancy ≤ 1, or next occupancy = 2 with no completion possible (never needed; keep simple).
  - Decided rule: in_rdy_next = (occ_next < 2).
  - One slot of slack is guaranteed, so the single in-flight completing beat always has a free slot.
- Simultaneous push and pop: occupancy unchanged, head advances, new entry appended; no bubble.
- Push into full queue: cannot occur by construction. Simulation assertion flags it as an error.
- in_vld && !in_rdy: beat not consumed. Upstream holds the value, its pipeline frozen by `en`. No state changes.
- Idle (in_vld=0): cnt and acc hold. Partial folds persist indefinitely.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): cnt=0, acc=0, occ=0, out_vld=0, out_acc=0, in_rdy=0.
- in_rdy rises on the first clk edge after rst deasserts.
- Reset mid-fold or with queued results: all partial and queued data discarded. The first beat after reset starts a new fold at cnt=0.
- Latency: completing beat accepted at edge k → out_vld=1 with result after edge k (visible cycle k+1) if queue was empty.
- Throughput: one beat per cycle while out_rdy=1. in_rdy never drops when out_rdy is held high.
- Backpressure:
  - With out_rdy=0, occ reaches 2 at the edge of the second unconsumed completion.
  - in_rdy reads 0 from the following cycle.
  - in_rdy returns to 1 the cycle after the first pop.
- Results leave in completion order; no reordering or loss.

## Test plan
- FOLD=4, SUM_WIDTH=8, ACC_WIDTH=12, SIGNED=1; beats −1,−1,−1,−1, out_rdy=1 → one result 0xFFC (−4), out_vld high exactly one cycle after 4th beat.
- Same config, continuous random beats for 509 folds, out_rdy=1 → in_rdy constantly 1. Each result equals reference sum mod 2^12 in order.
- Same config, out_rdy=0, 12 beats offered back-to-back → two results queued, in_rdy=0 after 8th accepted beat, 9th beat held. Then out_rdy=1 → results drain in order, in_rdy back to 1 next cycle, remaining fold completes correctly.
- ACC_WIDTH=8, SUM_WIDTH=8, FOLD=2, SIGNED=1; beats 100,100 → out_acc=0xC8 (wraps to −56).
- SIGNED=0, FOLD=1, SUM_WIDTH=8, ACC_WIDTH=10; beats 0xFF, 0x01 → results 255, 1 on consecutive cycles.
- FOLD=4; accept 2 beats, pulse rst → out_vld=0, in_rdy=0 during reset. Afterwards beats 1,2,3,4 → result 10 (no carry-over from pre-reset beats).
